xnor_pop_stream: RTL and testbench

- Streaming successor to the single-shot XNOR-popcount measurement wrapper.
- Accepts a binarized activation/weight vector of VEC_LEN bits as VEC_LEN/IN_W beats of IN_W bits over a valid/ready handshake.
- Accumulates the XNOR popcount, with optional majority-of-3 reduction, across the beats.
- Emits one result per vector (popcount plus binarized sign bit) through a one-entry buffered output handshake to the downstream activation/threshold stage.

---
 rtl/xnor_pop_stream_if.sv | 29 ++
 rtl/xnor_pop_stream.sv | 103 ++++++++++
 tb/tb_xnor_pop_stream.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/xnor_pop_stream_if.sv
// Stream bundle for xnor_pop_stream.
// Carries the beat input handshake and the buffered result handshake.
interface xnor_pop_stream_if #(
   parameter int IN_W    = 48,
   parameter int VEC_LEN = 576,
   parameter int MAJ_EN  = 0
);
   localparam int N_EFF = (MAJ_EN != 0) ? VEC_LEN / 3 : VEC_LEN;
   localparam int OUT_W = $clog2(N_EFF + 1);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_a;
   logic [IN_W-1:0]  in_w;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_pop;
   logic             out_bit;

   modport master (
      output in_valid, in_a, in_w, out_ready,
      input  in_ready, out_valid, out_pop, out_bit
   );

   modport slave (
      input  in_valid, in_a, in_w, out_ready,
      output in_ready, out_valid, out_pop, out_bit
   );
endinterface

// File: rtl/xnor_pop_stream.sv
// Streaming XNOR popcount over VEC_LEN-bit vectors sent as IN_W-bit beats,
// with optional majority-of-3 reduction and a one-entry result buffer.
module xnor_pop_stream #(
   parameter int IN_W    = 48,
   parameter int VEC_LEN = 576,
   parameter int MAJ_EN  = 0,
   localparam int BEATS  = VEC_LEN / IN_W,
   localparam int N_EFF  = (MAJ_EN != 0) ? VEC_LEN / 3 : VEC_LEN,
   localparam int OUT_W  = $clog2(N_EFF + 1),
   localparam int BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic            clk,
   input  logic            reset,
   xnor_pop_stream_if.slave bus,
   output logic [BI_W-1:0] beat_idx
);
   localparam int G = (MAJ_EN != 0) ? IN_W / 3 : IN_W;

   if (VEC_LEN % IN_W != 0) begin : g_bad_len
      $error("VEC_LEN must be a multiple of IN_W");
   end
   if (MAJ_EN != 0 && IN_W % 3 != 0) begin : g_bad_maj
      $error("IN_W must be a multiple of 3 when MAJ_EN=1");
   end

   logic [IN_W-1:0]  x;
   logic [G-1:0]     terms;
   logic [OUT_W-1:0] cnt;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] sum;
   logic [OUT_W:0]   dbl;
   logic             last;
   logic             take;
   logic             valid_q;
   logic [OUT_W-1:0] pop_q;
   logic             bit_q;

   assign x = ~(bus.in_a ^ bus.in_w);

   if (MAJ_EN != 0) begin : g_maj
      for (genvar k = 0; k < G; k++) begin : g_grp
         assign terms[k] = (x[3*k] & x[3*k+1]) |
                           (x[3*k] & x[3*k+2]) |
                           (x[3*k+1] & x[3*k+2]);
      end
   end else begin : g_plain
      assign terms = x;
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < G; i++) begin
         cnt = cnt + OUT_W'(terms[i]);
      end
   end

   // acc never exceeds N_EFF, so OUT_W bits cannot wrap
   assign sum  = acc + cnt;
   assign dbl  = {sum, 1'b0};
   assign last = (beat_idx == BI_W'(BEATS - 1));
   assign take = bus.in_valid && bus.in_ready;

   // only the closing beat can collide with a held result
   assign bus.in_ready  = !last || !valid_q || bus.out_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_pop   = pop_q;
   assign bus.out_bit   = bit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         valid_q <= 1'b0;
         pop_q   <= '0;
         bit_q   <= 1'b0;
      end else begin
         if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
         end
         if (take) begin
            if (last) begin
               pop_q   <= sum;
               bit_q   <= dbl > (OUT_W+1)'(N_EFF);
               valid_q <= 1'b1;
               acc     <= '0;
            end else begin
               acc     <= sum;
            end
         end
      end
   end

   if (BEATS > 1) begin : g_idx
      always_ff @(posedge clk) begin
         if (reset) begin
            beat_idx <= '0;
         end else if (take) begin
            beat_idx <= last ? '0 : beat_idx + 1'b1;
         end
      end
   end else begin : g_idx1
      assign beat_idx = '0;
   end
endmodule

// File: tb/tb_xnor_pop_stream.sv
// Directed bench for xnor_pop_stream: a plain-mode and a majority-mode
// instance share one beat stream; results are checked against hand values.
module tb_xnor_pop_stream;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] bi0;
   logic [3:0] bi1;
   bit   maj_on = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   nres = 0;

   xnor_pop_stream_if #(.IN_W(48), .VEC_LEN(576), .MAJ_EN(0)) b0 ();
   xnor_pop_stream_if #(.IN_W(48), .VEC_LEN(576), .MAJ_EN(1)) b1 ();

   xnor_pop_stream #(.IN_W(48), .VEC_LEN(576), .MAJ_EN(0)) d0 (
      .clk(clk), .reset(reset), .bus(b0), .beat_idx(bi0));
   xnor_pop_stream #(.IN_W(48), .VEC_LEN(576), .MAJ_EN(1)) d1 (
      .clk(clk), .reset(reset), .bus(b1), .beat_idx(bi1));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && b0.out_valid && b0.out_ready) nres <= nres + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [47:0] a, input logic [47:0] w);
      int n = 0;
      b0.in_valid = 1'b1;
      b0.in_a = a;
      b0.in_w = w;
      b1.in_valid = maj_on;
      b1.in_a = a;
      b1.in_w = w;
      while (!b0.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("in_ready_wait", 32'(b0.in_ready), 1);
      tick();
      b0.in_valid = 1'b0;
      b1.in_valid = 1'b0;
   endtask

   function automatic logic [47:0] rnd48();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[47:0];
   endfunction

   task automatic vec(input logic [47:0] m, input int nb);
      logic [47:0] a;
      for (int i = 0; i < nb; i++) begin
         a = rnd48();
         beat(a, a ^ m);
      end
   endtask

   function automatic int maj_cnt(input logic [47:0] x);
      int c = 0;
      for (int k = 0; k < 16; k++) begin
         if (int'(x[3*k]) + int'(x[3*k+1]) + int'(x[3*k+2]) >= 2) c++;
      end
      return c;
   endfunction

   task automatic res0(input string tag, input int pop, input bit b);
      check({tag, "_v0"}, 32'(b0.out_valid), 1);
      check({tag, "_pop0"}, 32'(b0.out_pop), pop);
      check({tag, "_bit0"}, 32'(b0.out_bit), 32'(b));
   endtask

   task automatic res1(input string tag, input int pop, input bit b);
      check({tag, "_v1"}, 32'(b1.out_valid), 1);
      check({tag, "_pop1"}, 32'(b1.out_pop), pop);
      check({tag, "_bit1"}, 32'(b1.out_bit), 32'(b));
   endtask

   initial begin
      logic [47:0] a;
      logic [47:0] w;
      int p0;
      int p1;
      int n0;
      b0.in_valid = 1'b0;
      b0.in_a = '0;
      b0.in_w = '0;
      b0.out_ready = 1'b1;
      b1.in_valid = 1'b0;
      b1.in_a = '0;
      b1.in_w = '0;
      b1.out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", 32'(b0.out_valid), 0);
      check("rst_pop", 32'(b0.out_pop), 0);
      check("rst_bit", 32'(b0.out_bit), 0);
      check("rst_idx", 32'(bi0), 0);
      check("rst_ready", 32'(b0.in_ready), 1);
      check("rst_valid1", 32'(b1.out_valid), 0);

      vec(48'h0, 5);
      check("mid_idx", 32'(bi0), 5);
      vec(48'h0, 7);
      res0("allmatch", 576, 1'b1);
      check("allmatch_idx", 32'(bi0), 0);
      vec({48{1'b1}}, 12);
      res0("nomatch", 0, 1'b0);
      vec(48'hFFFF_FF00_0000, 12);
      res0("tie288", 288, 1'b0);
      vec(48'hFFFF_FE00_0000, 12);
      res0("above300", 300, 1'b1);

      maj_on = 1'b1;
      vec({16{3'b100}}, 12);
      res0("g2_plain", 384, 1'b1);
      res1("g2_maj", 192, 1'b1);
      vec({16{3'b110}}, 12);
      res0("g1_plain", 192, 1'b0);
      res1("g1_maj", 0, 1'b0);
      vec({8{6'b111000}}, 12);
      res0("g30_plain", 288, 1'b0);
      res1("g30_maj", 96, 1'b0);
      maj_on = 1'b0;
      tick();

      b0.out_ready = 1'b0;
      vec(48'h0, 12);
      res0("bp_first", 576, 1'b1);
      vec({48{1'b1}}, 11);
      res0("bp_hold", 576, 1'b1);
      check("bp_idx", 32'(bi0), 11);
      a = rnd48();
      b0.in_valid = 1'b1;
      b0.in_a = a;
      b0.in_w = ~a;
      for (int i = 0; i < 3; i++) begin
         check("bp_stall", 32'(b0.in_ready), 0);
         tick();
      end
      res0("bp_still", 576, 1'b1);
      b0.out_ready = 1'b1;
      #1;
      check("bp_release", 32'(b0.in_ready), 1);
      tick();
      b0.in_valid = 1'b0;
      res0("bp_second", 0, 1'b0);
      tick();
      check("bp_drain", 32'(b0.out_valid), 0);
      check("bp_keep", 32'(b0.out_pop), 0);

      maj_on = 1'b1;
      tick();
      n0 = nres;
      for (int v = 0; v < 50; v++) begin
         p0 = 0;
         p1 = 0;
         for (int b = 0; b < 12; b++) begin
            if ($urandom_range(0, 9) < 3) begin
               repeat ($urandom_range(1, 2)) tick();
            end
            a = rnd48();
            w = rnd48();
            p0 += $countones(~(a ^ w));
            p1 += maj_cnt(~(a ^ w));
            beat(a, w);
         end
         res0("rnd", p0, 2 * p0 > 576);
         res1("rnd", p1, 2 * p1 > 192);
      end
      tick();
      check("rnd_count", 32'(nres - n0), 50);
      maj_on = 1'b0;

      b0.out_ready = 1'b0;
      vec(48'h0, 12);
      vec(48'h0, 5);
      check("rr_pending", 32'(b0.out_valid), 1);
      check("rr_idx5", 32'(bi0), 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rr_valid", 32'(b0.out_valid), 0);
      check("rr_idx", 32'(bi0), 0);
      check("rr_pop", 32'(b0.out_pop), 0);
      b0.out_ready = 1'b1;
      vec(48'h0, 12);
      res0("rr_clean", 576, 1'b1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
